// File: rtl/vmul_group_sequencer_pkg.sv
// vmul_seq_pkg: definitions shared by the vector-multiply group sequencer.
//   seq_state_t : sequencer state (IDLE / ISSUE / DRAIN)
//   OPW         : multiply opcode width
//   clog2       : constant ceiling-log2, used to size group indices
package vmul_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;

  localparam int OPW = 5;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vmul_group_sequencer_grp_find.sv
// vmul_grp_find: combinational search for the next lane group to issue.
//   mask   in  NUMGROUPS*NUMMULS : effective lane mask
//   cursor in  GW                : lowest group index still eligible
//   found  out 1                 : some group >= cursor has a nonzero slice
//   idx    out GW                : lowest such group index
//   last   out 1                 : no nonzero group exists above idx
module vmul_grp_find #(
  parameter int NUMGROUPS = 4,
  parameter int NUMMULS   = 4,
  parameter int GW        = 2
) (
  input  logic [NUMGROUPS*NUMMULS-1:0] mask,
  input  logic [GW-1:0]                cursor,
  output logic                         found,
  output logic [GW-1:0]                idx,
  output logic                         last
);

  logic [NUMGROUPS-1:0] slice_nz;

  generate
    for (genvar gi = 0; gi < NUMGROUPS; gi++) begin : g_nz
      assign slice_nz[gi] = |mask[gi*NUMMULS +: NUMMULS];
    end
  endgenerate

  always_comb begin
    found = 1'b0;
    idx   = '0;
    last  = 1'b1;
    // Descending scan so the lowest qualifying index is the one that sticks.
    for (int g = NUMGROUPS - 1; g >= 0; g--) begin
      if (slice_nz[g] && (g >= int'(cursor))) begin
        found = 1'b1;
        idx   = GW'(g);
      end
    end
    for (int g = 0; g < NUMGROUPS; g++) begin
      if (slice_nz[g] && (g > int'(idx))) begin
        last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/vmul_group_sequencer.sv
// vmul_group_sequencer: issues a masked vector multiply to NUMMULS physical
// multipliers one lane group per cycle, tracks the MULLAT-cycle multiplier
// latency for writeback and stalls upstream while an op is in flight.
//   clk, resetn        : clock, synchronous active-low reset
//   start, op, vmask   : op request (accepted when ready), opcode, lane mask
//   en                 : pipeline enable (0 freezes everything)
//   squash             : abort the in-flight op
//   ready, stall       : idle indication, upstream stall
//   grp_valid/sel/op/mask : group issuing to the multipliers this cycle
//   wr_en/wr_grp/wr_mask  : group whose results are on the result bus
//   done               : one-cycle pulse at completion
module vmul_group_sequencer
  import vmul_seq_pkg::*;
#(
  parameter int NUMLANES  = 16,
  parameter int NUMMULS   = 4,
  parameter int MULLAT    = 2,
  parameter int SKIPZERO  = 1,
  localparam int NUMGROUPS = NUMLANES / NUMMULS,
  localparam int GW        = (clog2(NUMGROUPS) < 1) ? 1 : clog2(NUMGROUPS)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [OPW-1:0]      op,
  input  logic [NUMLANES-1:0] vmask,
  input  logic                en,
  input  logic                squash,
  output logic                ready,
  output logic                stall,
  output logic                grp_valid,
  output logic [GW-1:0]       grp_sel,
  output logic [OPW-1:0]      grp_op,
  output logic [NUMMULS-1:0]  grp_mask,
  output logic                wr_en,
  output logic [GW-1:0]       wr_grp,
  output logic [NUMMULS-1:0]  wr_mask,
  output logic                done
);

  // Every stage except the output stage; used to see whether anything is
  // still outstanding behind the entry currently writing back.
  localparam logic [MULLAT-1:0] PEND_MASK = {MULLAT{1'b1}} >> 1;

  seq_state_t          state_reg;
  logic [GW-1:0]       cursor_reg;
  logic [OPW-1:0]      op_reg;
  logic [NUMLANES-1:0] mask_reg;

  logic [NUMLANES-1:0] eff_mask;
  logic                find_found;
  logic [GW-1:0]       find_idx;
  logic                find_last;
  logic                issue_fire;
  logic [NUMMULS-1:0]  issue_mask;
  logic                drain_done;
  logic                pend;

  logic [MULLAT-1:0]   pipe_v;
  logic [GW-1:0]       pipe_grp [MULLAT];
  logic [NUMMULS-1:0]  pipe_msk [MULLAT];

  // With skipping disabled every group issues, but the real mask slice still
  // travels with it so writeback can mask individual lanes.
  assign eff_mask = (SKIPZERO != 0) ? mask_reg : '1;

  vmul_grp_find #(
    .NUMGROUPS (NUMGROUPS),
    .NUMMULS   (NUMMULS),
    .GW        (GW)
  ) u_find (
    .mask   (eff_mask),
    .cursor (cursor_reg),
    .found  (find_found),
    .idx    (find_idx),
    .last   (find_last)
  );

  assign issue_fire = en && !squash && (state_reg == ST_ISSUE) && find_found;
  assign issue_mask = mask_reg[int'(find_idx)*NUMMULS +: NUMMULS];
  assign pend       = |(pipe_v & PEND_MASK);
  assign drain_done = en && !squash && (state_reg == ST_DRAIN) && !pend;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg  <= ST_IDLE;
      cursor_reg <= '0;
      op_reg     <= '0;
      mask_reg   <= '0;
    end else if (squash) begin
      state_reg <= ST_IDLE;
    end else if (en) begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            op_reg     <= op;
            mask_reg   <= vmask;
            cursor_reg <= '0;
            // An op with nothing to issue goes straight to DRAIN so it
            // still produces its done pulse.
            if ((SKIPZERO != 0) && (vmask == '0)) begin
              state_reg <= ST_DRAIN;
            end else begin
              state_reg <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (find_found) begin
            cursor_reg <= find_idx + GW'(1);
            if (find_last) begin
              state_reg <= ST_DRAIN;
            end
          end else begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!pend) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Latency pipe: stage 0 captures the issuing group, the last stage feeds
  // writeback. Squash drops every in-flight valid.
  generate
    for (genvar gi = 0; gi < MULLAT; gi++) begin : g_pipe
      logic               in_v;
      logic [GW-1:0]      in_grp;
      logic [NUMMULS-1:0] in_msk;
      logic               v_reg;
      logic [GW-1:0]      grp_reg;
      logic [NUMMULS-1:0] msk_reg;

      if (gi == 0) begin : g_head
        assign in_v   = issue_fire;
        assign in_grp = find_idx;
        assign in_msk = issue_mask;
      end else begin : g_body
        assign in_v   = pipe_v[gi-1];
        assign in_grp = pipe_grp[gi-1];
        assign in_msk = pipe_msk[gi-1];
      end

      always_ff @(posedge clk) begin
        if (!resetn) begin
          v_reg   <= 1'b0;
          grp_reg <= '0;
          msk_reg <= '0;
        end else if (squash) begin
          v_reg <= 1'b0;
        end else if (en) begin
          v_reg   <= in_v;
          grp_reg <= in_grp;
          msk_reg <= in_msk;
        end
      end

      assign pipe_v[gi]   = v_reg;
      assign pipe_grp[gi] = grp_reg;
      assign pipe_msk[gi] = msk_reg;
    end
  endgenerate

  assign ready     = (state_reg == ST_IDLE);
  assign done      = drain_done;
  assign stall     = (state_reg != ST_IDLE) && !drain_done;
  assign grp_valid = issue_fire;
  assign grp_sel   = issue_fire ? find_idx : '0;
  assign grp_op    = issue_fire ? op_reg : '0;
  assign grp_mask  = issue_fire ? issue_mask : '0;
  assign wr_en     = en && !squash && pipe_v[MULLAT-1];
  assign wr_grp    = wr_en ? pipe_grp[MULLAT-1] : '0;
  assign wr_mask   = wr_en ? pipe_msk[MULLAT-1] : '0;

endmodule
